// File: rtl/sic1_loader_pkg.sv
// Shared types and constants for the SIC-1 byte-stream program loader.
package sic1_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STOP_WAIT,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_START_PC,
        ST_RUN_EDGE
    } state_t;

    localparam logic [7:0] SYNC_LOAD     = 8'hA5;
    localparam logic [7:0] SYNC_STOP     = 8'h5A;
    localparam logic [7:0] MAX_PROG_ADDR = 8'd252;

    function automatic logic acceptsBytes(input state_t s);
        return (s == ST_IDLE) || (s == ST_ADDR) || (s == ST_LEN) ||
               (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/sic1_loader_timer.sv
// Inter-byte idle timer: reloads on clear, counts down while enabled, flags zero.
module sic1_loader_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LOAD_VALUE = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_count;

    // Saturates at zero so the expired flag stays up until the next reload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= LOAD_VALUE;
        end else if (i_clear) begin
            r_count <= LOAD_VALUE;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/sic1_loader.sv
// Framed byte-stream loader: halts the SIC-1 core, writes a program through
// its halted-mode programming pins, verifies a checksum, then restarts it.
module sic1_loader
    import sic1_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       cpu_halted,
    output logic [7:0] cpu_data,
    output logic       cpu_set_pc,
    output logic       cpu_set_data,
    output logic       cpu_run,
    output logic       error
);

    state_t     r_state;
    state_t     w_nextState;

    logic [7:0] r_addr;
    logic [7:0] r_sum;
    logic [7:0] r_remaining;

    logic       r_inReady;
    logic [7:0] r_data;
    logic       r_setPc;
    logic       r_setData;
    logic       r_run;
    logic       r_error;

    logic       w_nxtInReady;
    logic [7:0] w_nxtData;
    logic       w_nxtSetPc;
    logic       w_nxtSetData;
    logic       w_nxtRun;
    logic       w_nxtError;

    logic       w_accept;
    logic       w_inFrame;
    logic       w_expired;
    logic       w_timeout;
    logic [8:0] w_endAddr;
    logic       w_lenBad;
    logic       w_chkGood;

    assign w_accept  = in_valid && r_inReady;
    assign w_inFrame = (r_state == ST_ADDR) || (r_state == ST_LEN) ||
                       (r_state == ST_DATA) || (r_state == ST_CHK);
    assign w_timeout = w_inFrame && !w_accept && w_expired;

    // End address is one past the last written byte, so it may reach 253.
    assign w_endAddr = {1'b0, r_addr} + {1'b0, in_byte};
    assign w_lenBad  = (in_byte == 8'd0) || (w_endAddr > ({1'b0, MAX_PROG_ADDR} + 9'd1));
    assign w_chkGood = ((r_sum + in_byte) == 8'h00);

    sic1_loader_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_accept || !w_inFrame),
        .i_enable (w_inFrame),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:      if (w_accept && (in_byte == SYNC_LOAD)) w_nextState = ST_STOP_WAIT;
            ST_STOP_WAIT: if (cpu_halted && !r_run) w_nextState = ST_ADDR;
            ST_ADDR:      if (w_accept) w_nextState = ST_LEN;
            ST_LEN:       if (w_accept) w_nextState = w_lenBad ? ST_IDLE : ST_DATA;
            ST_DATA:      if (w_accept && (r_remaining == 8'd1)) w_nextState = ST_CHK;
            ST_CHK:       if (w_accept) w_nextState = w_chkGood ? ST_START_PC : ST_IDLE;
            ST_START_PC:  w_nextState = ST_RUN_EDGE;
            ST_RUN_EDGE:  w_nextState = ST_IDLE;
            default:      w_nextState = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_nextState = ST_IDLE;
        end
    end

    // Computes the values every registered output takes after this edge.
    always_comb begin
        w_nxtInReady = acceptsBytes(w_nextState);
        w_nxtData    = r_data;
        w_nxtSetPc   = 1'b0;
        w_nxtSetData = 1'b0;
        w_nxtRun     = r_run;
        w_nxtError   = r_error;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (in_byte == SYNC_STOP)) begin
                    w_nxtRun = 1'b0;
                end
                if (w_accept && (in_byte == SYNC_LOAD)) begin
                    w_nxtRun   = 1'b0;
                    w_nxtError = 1'b0;
                end
            end
            ST_ADDR: begin
                if (w_accept) begin
                    w_nxtSetPc = 1'b1;
                    w_nxtData  = in_byte;
                end
            end
            ST_LEN:  if (w_accept && w_lenBad) w_nxtError = 1'b1;
            ST_DATA: begin
                if (w_accept) begin
                    w_nxtSetData = 1'b1;
                    w_nxtData    = in_byte;
                end
            end
            ST_CHK:  if (w_accept && !w_chkGood) w_nxtError = 1'b1;
            ST_START_PC: begin
                w_nxtSetPc = 1'b1;
                w_nxtData  = r_addr;
            end
            ST_RUN_EDGE: w_nxtRun = 1'b1;
            default: ;
        endcase
        if (w_timeout) begin
            w_nxtError = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inReady <= 1'b1;
            r_data    <= 8'h00;
            r_setPc   <= 1'b0;
            r_setData <= 1'b0;
            r_run     <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_inReady <= w_nxtInReady;
            r_data    <= w_nxtData;
            r_setPc   <= w_nxtSetPc;
            r_setData <= w_nxtSetData;
            r_run     <= w_nxtRun;
            r_error   <= w_nxtError;
        end
    end

    // The running checksum starts from ADDR and absorbs every frame byte up to CHK.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr      <= 8'h00;
            r_sum       <= 8'h00;
            r_remaining <= 8'h00;
        end else if (w_accept) begin
            case (r_state)
                ST_ADDR: begin
                    r_addr <= in_byte;
                    r_sum  <= in_byte;
                end
                ST_LEN: begin
                    r_sum       <= r_sum + in_byte;
                    r_remaining <= in_byte;
                end
                ST_DATA: begin
                    r_sum       <= r_sum + in_byte;
                    r_remaining <= r_remaining - 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = r_inReady;
    assign cpu_data     = r_data;
    assign cpu_set_pc   = r_setPc;
    assign cpu_set_data = r_setData;
    assign cpu_run      = r_run;
    assign error        = r_error;

endmodule

// File: tb/tb_sic1_loader.sv
// Scoreboard bench for sic1_loader: stimulus queues the expected core pin
// events, a negedge monitor pops and compares them as the loader emits them.
module tb_sic1_loader;

    localparam int EV_PC   = 0;
    localparam int EV_DATA = 1;
    localparam int EV_RUN  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } event_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       cpu_halted = 1'b1;
    logic [7:0] cpu_data;
    logic       cpu_set_pc;
    logic       cpu_set_data;
    logic       cpu_run;
    logic       error;

    event_t expQ[$];
    int     checks = 0;
    int     errors = 0;
    logic   prevRun = 1'b0;

    always #5 clk = ~clk;

    sic1_loader #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cpu_halted  (cpu_halted),
        .cpu_data    (cpu_data),
        .cpu_set_pc  (cpu_set_pc),
        .cpu_set_data(cpu_set_data),
        .cpu_run     (cpu_run),
        .error       (error)
    );

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic expectEvent(input int kind, input logic [7:0] data);
        event_t e;
        e.kind = kind;
        e.data = data;
        expQ.push_back(e);
    endtask

    task automatic expectLoad(input logic [7:0] addr, input logic withRun);
        expectEvent(EV_PC, addr);
        expectEvent(EV_DATA, 8'h01);
        expectEvent(EV_DATA, 8'h02);
        expectEvent(EV_DATA, 8'h03);
        if (withRun) begin
            expectEvent(EV_PC, addr);
            expectEvent(EV_RUN, 8'h00);
        end
    endtask

    task automatic observe(input int kind, input logic [7:0] data);
        event_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event: got kind %0d data 0x%02h, expected none", kind, data);
        end else begin
            e = expQ.pop_front();
            if ((e.kind != kind) || (e.data !== data)) begin
                errors++;
                $display("[TB] FAIL event_order: got kind %0d data 0x%02h, expected kind %0d data 0x%02h",
                         kind, data, e.kind, e.data);
            end
        end
    endtask

    // Monitor: every pulse or run rising edge must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cpu_set_pc) observe(EV_PC, cpu_data);
            if (cpu_set_data) observe(EV_DATA, cpu_data);
            if (cpu_run && !prevRun) observe(EV_RUN, 8'h00);
            if (cpu_set_pc || cpu_set_data) begin
                checks++;
                if ((cpu_set_pc && cpu_set_data) || cpu_run) begin
                    errors++;
                    $display("[TB] FAIL pulse_exclusive: got pc=%b data=%b run=%b, expected one pulse with run=0",
                             cpu_set_pc, cpu_set_data, cpu_run);
                end
            end
        end
        prevRun <= cpu_run;
    end

    task automatic applyStimulus(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_byte  = b;
        in_valid = 1'b1;
        while (!in_ready && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_wait: byte 0x%02h not accepted, got in_ready=0, expected 1", b);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic sendLoadFrame(input logic [7:0] addr, input logic [7:0] chk);
        applyStimulus(8'hA5);
        applyStimulus(addr);
        applyStimulus(8'h03);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        applyStimulus(chk);
    endtask

    task automatic waitRun();
        int n = 0;
        while (!cpu_run && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        checkBit("run_rise", cpu_run, 1'b1);
    endtask

    task automatic checkQueueEmpty(input string name);
        @(posedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s: got %0d pending events, expected 0", name, expQ.size());
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkBit({tag, "_in_ready"}, in_ready, 1'b1);
        checkBit({tag, "_run"}, cpu_run, 1'b0);
        checkBit({tag, "_set_pc"}, cpu_set_pc, 1'b0);
        checkBit({tag, "_set_data"}, cpu_set_data, 1'b0);
        checkOutput({tag, "_data"}, cpu_data, 8'h00);
        checkBit({tag, "_error"}, error, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");

        $display("[TB] load and run");
        cpu_halted = 1'b1;
        expectLoad(8'h10, 1'b1);
        sendLoadFrame(8'h10, 8'hE7);
        waitRun();
        checkBit("load_error", error, 1'b0);
        checkQueueEmpty("load_events");

        $display("[TB] stop while running");
        applyStimulus(8'h5A);
        @(negedge clk);
        checkBit("stop_run", cpu_run, 1'b0);

        expectLoad(8'h10, 1'b1);
        sendLoadFrame(8'h10, 8'hE7);
        waitRun();
        cpu_halted = 1'b0;
        applyStimulus(8'hA5);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkBit("stopwait_ready", in_ready, 1'b0);
        end
        checkBit("stopwait_run", cpu_run, 1'b0);
        checkQueueEmpty("stopwait_events");
        cpu_halted = 1'b1;
        expectLoad(8'h10, 1'b1);
        applyStimulus(8'h10);
        applyStimulus(8'h03);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        applyStimulus(8'hE7);
        waitRun();
        checkQueueEmpty("resume_events");

        $display("[TB] bad checksum");
        expectLoad(8'h10, 1'b0);
        sendLoadFrame(8'h10, 8'h00);
        repeat (6) @(negedge clk);
        checkBit("badchk_error", error, 1'b1);
        checkBit("badchk_run", cpu_run, 1'b0);
        checkQueueEmpty("badchk_events");

        $display("[TB] range check");
        expectEvent(EV_PC, 8'hFB);
        applyStimulus(8'hA5);
        @(negedge clk);
        checkBit("sync_clears_error", error, 1'b0);
        applyStimulus(8'hFB);
        applyStimulus(8'h03);
        @(negedge clk);
        checkBit("range_error", error, 1'b1);
        checkBit("range_idle_ready", in_ready, 1'b1);
        repeat (5) @(negedge clk);
        checkQueueEmpty("range_events");

        $display("[TB] timeout");
        expectEvent(EV_PC, 8'h20);
        applyStimulus(8'hA5);
        applyStimulus(8'h20);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 15) checkBit("timeout_early", error, 1'b0);
        end
        checkBit("timeout_error", error, 1'b1);
        checkBit("timeout_idle_ready", in_ready, 1'b1);
        checkBit("timeout_run", cpu_run, 1'b0);
        checkQueueEmpty("timeout_events");

        $display("[TB] reset mid-frame");
        expectEvent(EV_PC, 8'h10);
        expectEvent(EV_DATA, 8'h01);
        applyStimulus(8'hA5);
        applyStimulus(8'h10);
        applyStimulus(8'h03);
        applyStimulus(8'h01);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_byte  = 8'h02;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkResetValues("midreset");
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkQueueEmpty("midreset_events");
        expectLoad(8'h10, 1'b1);
        sendLoadFrame(8'h10, 8'hE7);
        waitRun();
        checkBit("reload_error", error, 1'b0);
        checkQueueEmpty("reload_events");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sic1_loader.md
# sic1_loader

Byte-stream program loader sitting directly upstream of the SIC-1 SUBLEQ core. It consumes framed bytes (from a UART receiver or host bridge) over a valid/ready handshake. It stops the core, writes the payload through the core's halted-mode programming pins (`set_pc` / `set_data` / `ui_in`), verifies a checksum and then starts the core by raising `run`.

## Interface
- `TIMEOUT_CYCLES`, default 100000: max idle cycles between bytes inside a frame before abort.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_byte`  in  8  incoming stream byte.
- `in_valid`  in  1  `in_byte` valid.
- `in_ready`  out  1  loader accepts `in_byte` this cycle (transfer = valid & ready).
- `cpu_halted`  in  1  core halted status.
- `cpu_data`  out  8  drives core `ui_in` (address or data byte).
- `cpu_set_pc`  out  1  one-cycle PC load pulse.
- `cpu_set_data`  out  1  one-cycle write-and-increment pulse.
- `cpu_run`  out  1  core run level.
- `error`  out  1  sticky; set on bad frame, cleared on next valid sync byte.

## Operation
- Frame formats:
  - Stop: `0x5A`.
  - Load: `0xA5`, ADDR, LEN, LEN data bytes, CHK.
  - Checksum rule: (ADDR+LEN+Σdata+CHK) mod 256 == 0.
- States: IDLE, STOP_WAIT, ADDR, LEN, DATA, CHK, START_PC, RUN_EDGE.
- IDLE:
  - `in_ready`=1.
  - `0x5A` → `cpu_run`←0, stay IDLE.
  - `0xA5` → `cpu_run`←0, clear `error`, go STOP_WAIT.
  - Any other byte is discarded.
- STOP_WAIT:
  - `in_ready`=0.
  - Go ADDR in the first cycle `cpu_halted`=1 is sampled with `cpu_run` already 0.
- ADDR:
  - On accept, latch start address.
  - Next cycle `cpu_set_pc`=1, `cpu_data`=ADDR.
  - Go LEN.
- LEN:
  - On accept, compute the 9-bit sum ADDR+LEN.
  - LEN==0 or ADDR+LEN>253 (the last written byte must be ≤252) → `error`←1, IDLE.
  - Otherwise go DATA, with the remaining counter ← LEN.
- DATA:
  - Each accepted byte gives, next cycle, `cpu_set_data`=1 and `cpu_data`=byte.
  - The byte is also accumulated into the 8-bit checksum.
  - Back-to-back accepts are legal; the core increments PC once per pulse.
  - After LEN bytes, go CHK.
- CHK:
  - On accept: sum==0 → START_PC; otherwise `error`←1, IDLE.
  - Memory already written is not rolled back.
- START_PC: one cycle with `cpu_set_pc`=1 and `cpu_data`=latched ADDR. Go RUN_EDGE.
- RUN_EDGE: `cpu_run`←1 (registered), go IDLE.
- `cpu_run` stays 1 until a stop or load frame. The core may halt on its own; rerunning requires a new load frame.
- Timeout:
  - In ADDR, LEN, DATA or CHK, a counter reloads on every accept.
  - Reaching `TIMEOUT_CYCLES` with no accept → `error`←1, IDLE. `cpu_run` stays 0.
- `in_ready`=1 only in IDLE, ADDR, LEN, DATA and CHK.

## Timing
- All outputs are registered.
- Reset values: `cpu_run`=0, `cpu_set_pc`=0, `cpu_set_data`=0, `cpu_data`=0x00, `error`=0, state IDLE, `in_ready`=1 in the cycle after reset.
- Latency:
  - Byte accept → corresponding pulse: exactly 1 cycle.
  - CHK accept → `cpu_set_pc`: 2 cycles. This pulse is never in the same cycle as `cpu_run` rising; `cpu_run` rises 1 cycle after it.
- Pulse exclusivity: `cpu_set_pc` and `cpu_set_data` are never high together, and neither is high while `cpu_run`=1.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values. No partial pulse may appear after reset.
- `in_valid` dropping mid-frame simply stalls; only the timeout aborts.

## Structure
- Package `sic1_loader_pkg` contains:
  - the state enum;
  - `SYNC_LOAD`=8'hA5 and `SYNC_STOP`=8'h5A;
  - `MAX_PROG_ADDR`=8'd252.
- Sub-module `sic1_loader_timer`: loadable down-counter with `clear`, `enable` and `expired`, width derived from `TIMEOUT_CYCLES` via `$clog2`.

## Test plan
- Load and run:
  - Stimulus: frame A5,10,03,01,02,03,E7 with the core halted.
  - Required: `set_pc` with data 0x10; then three consecutive `set_data` pulses carrying 01,02,03; then `set_pc` with data 0x10; then `cpu_run` rises; `error`=0.
- Bad checksum:
  - Stimulus: same frame with CHK=00.
  - Required: three data pulses, no second `set_pc`, `cpu_run` stays 0, `error`=1.
- Range check:
  - Stimulus: ADDR=FB, LEN=03.
  - Required: `error`=1 immediately after LEN, no `set_data` pulses.
- Stop while running:
  - Stimulus: `cpu_run`=1, then send 5A.
  - Required: `cpu_run`=0 next cycle.
  - Stimulus: a second load frame while `cpu_halted` is held 0 for 20 cycles.
  - Required: `in_ready`=0 throughout that wait, and no pulses are issued.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16; send A5,20 then stall.
  - Required: `error`=1 at cycle 16 after the last accept, then IDLE.
- Reset:
  - Stimulus: `rst_n` low in the middle of DATA.
  - Required: all outputs at reset values; the next A5 frame loads correctly.
